// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx: transmit end of the bsg_tag serial protocol.
// Accepts parallel tag packets on a valid/ready handshake and shifts them
// out one bit per clock on tag_en_o/tag_data_o. Frame order: start bit,
// len (LSB first), data_not_reset, node_id (LSB first), payload (LSB first),
// followed by gap_cycles_p idle cycles.
// Optional feature: define BSG_TAG_SERIAL_TX_MASTER_RESET_EN to add the
// master_reset_i input and the MRST state that emits the master reset
// sequence (reset_ones_p ones, then a single zero, all with en=1).
module bsg_tag_serial_tx #(
  parameter int els_p        = 64,
  parameter int lg_width_p   = 4,
  parameter int gap_cycles_p = 2,
  parameter int reset_ones_p = 64,
  // Same result as BSG_SAFE_CLOG2(els_p): never narrower than one bit
  localparam int lg_els_lp   = (els_p <= 1) ? 1 : $clog2(els_p),
  localparam int pay_w_lp    = (1 << lg_width_p) - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
  input  logic                  master_reset_i,
`endif
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [lg_els_lp-1:0]  node_id_i,
  input  logic                  data_not_reset_i,
  input  logic [lg_width_p-1:0] len_i,
  input  logic [pay_w_lp-1:0]   payload_i,
  output logic                  tag_en_o,
  output logic                  tag_data_o,
  output logic                  busy_o
);

  // The shared bit counter must hold the largest terminal count of any field
  localparam int max_a_lp   = (pay_w_lp > lg_els_lp) ? pay_w_lp : lg_els_lp;
  localparam int max_b_lp   = (max_a_lp > gap_cycles_p) ? max_a_lp : gap_cycles_p;
  localparam int max_c_lp   = (max_b_lp > reset_ones_p) ? max_b_lp : reset_ones_p;
  localparam int cnt_w_lp   = $clog2(max_c_lp + 2);

  localparam logic [cnt_w_lp-1:0] one_lp       = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] len_last_lp  = cnt_w_lp'(lg_width_p - 1);
  localparam logic [cnt_w_lp-1:0] node_last_lp = cnt_w_lp'(lg_els_lp - 1);
  localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'(gap_cycles_p - 1);
`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
  localparam logic [cnt_w_lp-1:0] ones_last_lp = cnt_w_lp'(reset_ones_p - 1);
  localparam logic [cnt_w_lp-1:0] ones_tail_lp = cnt_w_lp'(reset_ones_p);
`endif

  // The state names the field whose bit is currently on tag_data_o
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LEN   = 3'd2,
    S_DNR   = 3'd3,
    S_NODE  = 3'd4,
    S_PAY   = 3'd5,
    S_GAP   = 3'd6
`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
    ,S_MRST = 3'd7
`endif
  } state_e;

  state_e                r_state;
  logic [cnt_w_lp-1:0]   r_cnt;
  logic                  r_en;
  logic                  r_data;
  logic                  r_ready;
  logic                  r_busy;
  logic [lg_width_p-1:0] r_len;
  logic [lg_width_p-1:0] r_len_sh;
  logic                  r_dnr;
  logic [lg_els_lp-1:0]  r_node_sh;
  logic [pay_w_lp-1:0]   r_pay_sh;

  logic                  w_accept;
  logic [cnt_w_lp-1:0]   w_pay_last;

`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
  // A master reset request in IDLE wins over a pending packet
  assign w_accept = v_i & r_ready & ~master_reset_i;
`else
  assign w_accept = v_i & r_ready;
`endif

  // Last payload bit index; only consulted in PAY, where r_len is nonzero
  assign w_pay_last = cnt_w_lp'(r_len) - one_lp;

  // Serializer FSM; every output is a register updated with the state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_GAP;
      r_cnt     <= '0;
      r_en      <= 1'b0;
      r_data    <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_len     <= '0;
      r_len_sh  <= '0;
      r_dnr     <= 1'b0;
      r_node_sh <= '0;
      r_pay_sh  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
          if (master_reset_i) begin
            r_state <= S_MRST;
            r_en    <= 1'b1;
            r_data  <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else
`endif
          if (w_accept) begin
            r_len     <= len_i;
            r_len_sh  <= len_i;
            r_dnr     <= data_not_reset_i;
            r_node_sh <= node_id_i;
            r_pay_sh  <= payload_i;
            r_state   <= S_START;
            r_en      <= 1'b1;
            r_data    <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_en    <= 1'b0;
            r_data  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          r_state  <= S_LEN;
          r_cnt    <= '0;
          r_data   <= r_len_sh[0];
          r_len_sh <= r_len_sh >> 1;
        end
        S_LEN: begin
          if (r_cnt == len_last_lp) begin
            r_state <= S_DNR;
            r_cnt   <= '0;
            r_data  <= r_dnr;
          end else begin
            r_cnt    <= r_cnt + one_lp;
            r_data   <= r_len_sh[0];
            r_len_sh <= r_len_sh >> 1;
          end
        end
        S_DNR: begin
          r_state   <= S_NODE;
          r_cnt     <= '0;
          r_data    <= r_node_sh[0];
          r_node_sh <= r_node_sh >> 1;
        end
        S_NODE: begin
          if (r_cnt == node_last_lp) begin
            r_cnt <= '0;
            if (r_len == '0) begin
              r_state <= S_GAP;
              r_en    <= 1'b0;
              r_data  <= 1'b0;
            end else begin
              r_state  <= S_PAY;
              r_data   <= r_pay_sh[0];
              r_pay_sh <= r_pay_sh >> 1;
            end
          end else begin
            r_cnt     <= r_cnt + one_lp;
            r_data    <= r_node_sh[0];
            r_node_sh <= r_node_sh >> 1;
          end
        end
        S_PAY: begin
          if (r_cnt == w_pay_last) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_data  <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + one_lp;
            r_data   <= r_pay_sh[0];
            r_pay_sh <= r_pay_sh >> 1;
          end
        end
        S_GAP: begin
          r_en   <= 1'b0;
          r_data <= 1'b0;
          if (r_cnt == gap_last_lp) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + one_lp;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
`ifdef BSG_TAG_SERIAL_TX_MASTER_RESET_EN
        S_MRST: begin
          if (r_cnt == ones_tail_lp) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_data  <= 1'b0;
          end else if (r_cnt == ones_last_lp) begin
            r_cnt  <= r_cnt + one_lp;
            r_data <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + one_lp;
            r_data <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_GAP;
          r_cnt   <= '0;
          r_en    <= 1'b0;
          r_data  <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign tag_en_o   = r_en;
  assign tag_data_o = r_data;
  assign busy_o     = r_busy;

endmodule
